// File: rtl/disp_rst_seq.sv
// ---------------------------------------------------------------------------
// disp_rst_seq
//
// Display reset sequencer. Waits for the raw PLL lock flag to settle and
// then releases one active-low reset per display interface in a fixed,
// staggered order. Losing lock or a restart request pulls every reset low
// again. Lock losses seen after the first release are reported as a
// one-cycle pulse and, optionally, counted.
//
// Ports:
//   clk         display clock
//   rst         asynchronous, active-high reset
//   pll_locked  raw PLL lock flag, asynchronous to clk
//   restart     synchronous single-cycle request to re-run the sequence
//   out_rstn    per-interface resets, active-low
//               (bit 0 lcd, 1 vga, 2 hdmi, 3 mipi, 4 spilcd)
//   seq_done    high while every reset output is released
//   lock_lost   one-cycle pulse on lock loss after the first release
//   lost_cnt    saturating count of lock_lost pulses
//
// Parameters:
//   SYNC_STAGES  flops in the pll_locked synchroniser (>= 2)
//   HOLD_CYCLES  synchronised-locked cycles before the first release (>= 1)
//   STEP_CYCLES  cycles between successive releases (>= 1)
//   N_OUT        number of reset outputs
//
// Configuration macro:
//   DISP_RST_SEQ_LOST_CNT_EN  when defined, lost_cnt is an 8-bit saturating
//                             counter; otherwise lost_cnt is tied to zero.
// ---------------------------------------------------------------------------
module disp_rst_seq #(
    parameter int SYNC_STAGES = 2,
    parameter int HOLD_CYCLES = 16,
    parameter int STEP_CYCLES = 4,
    parameter int N_OUT       = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pll_locked,
    input  logic             restart,
    output logic [N_OUT-1:0] out_rstn,
    output logic             seq_done,
    output logic             lock_lost,
    output logic [7:0]       lost_cnt
);

    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int SW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam int IW = $clog2(N_OUT + 1);

    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [SW-1:0] STEP_LAST = SW'(STEP_CYCLES - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(N_OUT - 1);

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        HOLD      = 2'd1,
        RELEASE   = 2'd2,
        RUN       = 2'd3
    } state_t;

    state_t                 state, state_n;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   lk_s;
    logic                   restart_q;
    logic [HW-1:0]          hold_cnt, hold_cnt_n;
    logic [SW-1:0]          step_cnt, step_cnt_n;
    logic [IW-1:0]          idx, idx_n;
    logic [N_OUT-1:0]       out_rstn_n;
    logic                   seq_done_n;
    logic                   lock_lost_n;

    assign lk_s = sync_q[SYNC_STAGES-1];

    // Lock flag synchroniser. The restart request is registered alongside it
    // so the FSM acts on restart one edge after it is sampled, giving the
    // first release at R+1+HOLD_CYCLES.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q    <= '0;
            restart_q <= 1'b0;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], pll_locked};
            restart_q <= restart;
        end
    end

    // State, counters and all visible outputs are registered here so no
    // input can reach an output combinationally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= WAIT_LOCK;
            hold_cnt  <= '0;
            step_cnt  <= '0;
            idx       <= '0;
            out_rstn  <= '0;
            seq_done  <= 1'b0;
            lock_lost <= 1'b0;
        end else begin
            state     <= state_n;
            hold_cnt  <= hold_cnt_n;
            step_cnt  <= step_cnt_n;
            idx       <= idx_n;
            out_rstn  <= out_rstn_n;
            seq_done  <= seq_done_n;
            lock_lost <= lock_lost_n;
        end
    end

    // Next-state logic. Lock loss is tested before restart in every state
    // where both apply, so a simultaneous restart is swallowed by the loss.
    always_comb begin
        state_n     = state;
        hold_cnt_n  = hold_cnt;
        step_cnt_n  = step_cnt;
        idx_n       = idx;
        out_rstn_n  = out_rstn;
        seq_done_n  = seq_done;
        lock_lost_n = 1'b0;

        case (state)
            WAIT_LOCK: begin
                out_rstn_n = '0;
                seq_done_n = 1'b0;
                if (lk_s) begin
                    state_n    = HOLD;
                    hold_cnt_n = '0;
                end
            end

            HOLD: begin
                out_rstn_n = '0;
                seq_done_n = 1'b0;
                if (!lk_s) begin
                    // Nothing was released yet, so this is not reported.
                    state_n = WAIT_LOCK;
                end else if (restart_q) begin
                    hold_cnt_n = '0;
                end else if (hold_cnt == HOLD_LAST) begin
                    out_rstn_n = N_OUT'(1);
                    idx_n      = IW'(1);
                    step_cnt_n = '0;
                    if (N_OUT == 1) begin
                        seq_done_n = 1'b1;
                        state_n    = RUN;
                    end else begin
                        state_n    = RELEASE;
                    end
                end else begin
                    hold_cnt_n = hold_cnt + 1'b1;
                end
            end

            RELEASE, RUN: begin
                if (!lk_s) begin
                    out_rstn_n  = '0;
                    seq_done_n  = 1'b0;
                    lock_lost_n = 1'b1;
                    state_n     = WAIT_LOCK;
                end else if (restart_q) begin
                    out_rstn_n = '0;
                    seq_done_n = 1'b0;
                    hold_cnt_n = '0;
                    state_n    = HOLD;
                end else if (state == RELEASE) begin
                    if (step_cnt == STEP_LAST) begin
                        step_cnt_n = '0;
                        out_rstn_n = out_rstn | (N_OUT'(1) << idx);
                        idx_n      = idx + 1'b1;
                        if (idx == IDX_LAST) begin
                            seq_done_n = 1'b1;
                            state_n    = RUN;
                        end
                    end else begin
                        step_cnt_n = step_cnt + 1'b1;
                    end
                end
            end

            default: begin
                out_rstn_n = '0;
                seq_done_n = 1'b0;
                state_n    = WAIT_LOCK;
            end
        endcase
    end

`ifdef DISP_RST_SEQ_LOST_CNT_EN
    logic [7:0] lost_cnt_q;

    // Counts on the same edge that raises lock_lost; sticks at 255.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lost_cnt_q <= 8'd0;
        end else if (lock_lost_n && (lost_cnt_q != 8'hFF)) begin
            lost_cnt_q <= lost_cnt_q + 8'd1;
        end
    end

    assign lost_cnt = lost_cnt_q;
`else
    assign lost_cnt = 8'd0;
`endif

endmodule

// File: doc/disp_rst_seq.md
# disp_rst_seq

Display reset sequencer: sits downstream of the display clock/reset distribution and consumes the shared display clock and a raw PLL lock flag. It releases one active-low reset per display interface (LCD, VGA, HDMI, MIPI, SPI-LCD) in a fixed, staggered order once lock is stable. It re-asserts all of them if lock is lost or a restart is requested. It also reports lock-loss events to the control/status logic.

## Interface
Parameters:
- SYNC_STAGES, 2: flops in the `pll_locked` synchroniser (legal ≥ 2).
- HOLD_CYCLES, 16: consecutive synchronised-locked cycles required before the first release (legal ≥ 1).
- STEP_CYCLES, 4: cycles between successive reset releases (legal ≥ 1).
- N_OUT, 5: number of reset outputs. Bit order: 0 lcd, 1 vga, 2 hdmi, 3 mipi, 4 spilcd.

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  display clock
- `rst`  in  1  asynchronous, active-high reset
- `pll_locked`  in  1  raw lock flag, asynchronous to `clk`
- `restart`  in  1  synchronous single-cycle request to re-run the sequence
- `out_rstn`  out  N_OUT  per-interface resets, active-low, registered
- `seq_done`  out  1  high while all outputs are released
- `lock_lost`  out  1  one-cycle pulse on lock loss after the first release
- `lost_cnt`  out  8  saturating count of `lock_lost` pulses

## Operation
- Reset (`rst`=1) takes effect immediately, with no clock required:
  - all synchroniser flops 0
  - `out_rstn`=0, `seq_done`=0, `lock_lost`=0, `lost_cnt`=0
  - state WAIT_LOCK, counters 0
- `lk_s` is `pll_locked` after SYNC_STAGES flops.
- States:
  - WAIT_LOCK: all `out_rstn`=0. When `lk_s`=1, go to HOLD with `hold_cnt`=0.
  - HOLD: `hold_cnt` increments each cycle. If `lk_s`=0, return to WAIT_LOCK with no pulse. When `hold_cnt`=HOLD_CYCLES-1 with `lk_s`=1, set `out_rstn[0]`=1 and go to RELEASE with `idx`=1 and `step_cnt`=0.
  - RELEASE: `step_cnt` counts 0..STEP_CYCLES-1. At wrap, set `out_rstn[idx]`=1 and increment `idx`. When the bit N_OUT-1 is set, set `seq_done`=1 in the same edge and go to RUN.
  - RUN: hold outputs until a lock loss or restart.
- Lock loss (`lk_s`=0 in RELEASE or RUN), on the same edge:
  - all `out_rstn`=0, `seq_done`=0
  - `lock_lost`=1 for one cycle
  - `lost_cnt`+1, saturating at 255
  - go to WAIT_LOCK
- `restart`=1 in HOLD, RELEASE or RUN with `lk_s`=1: all outputs 0, `seq_done`=0, go to HOLD with `hold_cnt`=0. No pulse, no count.
- `restart` in WAIT_LOCK is ignored.
- `restart` and lock loss in the same cycle: lock loss wins (pulse, count, WAIT_LOCK).
- Released bits never deassert out of order. Outputs only go all-low together.

## Timing
- Let E0 be the first edge sampling `pll_locked`=1, with lock held stable.
  - FSM sees `lk_s`=1 at edge E0+SYNC_STAGES.
  - `out_rstn[k]` rises at edge E0+SYNC_STAGES+HOLD_CYCLES+k·STEP_CYCLES.
  - `seq_done` rises at the same edge as `out_rstn[N_OUT-1]`.
- Let E1 be the first edge sampling `pll_locked`=0. `out_rstn` all fall, and `lock_lost` rises, at edge E1+SYNC_STAGES.
- `restart` sampled at edge R: outputs low after R. `out_rstn[0]` rises at R+1+HOLD_CYCLES.
- Lock pulses shorter than SYNC_STAGES cycles may be filtered. Any glitch that reaches `lk_s` is honoured.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Configuration
- `DISP_RST_SEQ_LOST_CNT_EN` defined: the 8-bit saturating `lost_cnt` counter is implemented as described.
- Not defined: `lost_cnt` is tied to 8'd0 and the counter logic is removed. `lock_lost` pulse behaviour is unchanged.

## Test plan
Default parameters (2/16/4/5), macro defined.
- Assert `rst`, then release; raise `pll_locked` at E0. Expect `out_rstn` = 00001 at E0+18, 00011 at +22, 00111 at +26, 01111 at +30, 11111 at +34, and `seq_done`=1 at +34.
- In HOLD, drop `pll_locked` for 3 cycles at hold count 10. Expect no `lock_lost` pulse, `out_rstn`=0, and the sequence restarts from a full 16-cycle hold.
- In RUN, drop `pll_locked` at E1. Expect `out_rstn`=0, `seq_done`=0, a one-cycle `lock_lost` pulse at E1+2, `lost_cnt`=1.
- Pulse `restart` and lose lock so both reach the FSM in the same cycle. Expect the lock-loss path: `lost_cnt` increments, state WAIT_LOCK.
- Cause 260 lock-loss events. Expect `lost_cnt` saturates at 255. With the macro undefined, `lost_cnt` stays 0.
- Assert `rst` mid-RELEASE with `out_rstn`=00111. Expect all outputs 0 immediately, without waiting for a clock edge.
